// File: rtl/idu_issue_ctrl_ysyx23060136.sv
// Issue controller between decode and EXU: one decoded instruction per cycle into a registered slot, with a RAW scoreboard.
// Latency: an issue in cycle t presents IDU_valid in cycle t+1. A retire clears its hazard one cycle later; there is no bypass.
// Backpressure: IDU_ready is combinational. It is low on a hazard, a full pipe, a held slot, flush, drain or halt.
// Ports: IFU_valid/IDU_ready plus the dec_* fields form the decode side. IDU_valid/EXU_ready/EXU_flush form the EXU side.
//        WB_* carry retire notifications. inflight, halted and sb_err are status outputs.
module idu_issue_ctrl_ysyx23060136 #(
    parameter int MAX_INFLIGHT = 3,
    parameter int NREG         = 16,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IFU_valid,
    output logic             IDU_ready,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_write_gpr,
    input  logic             dec_read_csr,
    input  logic             dec_write_csr,
    input  logic             dec_serialize,
    input  logic             dec_halt,
    output logic             IDU_valid,
    input  logic             EXU_ready,
    input  logic             EXU_flush,
    input  logic             WB_valid,
    input  logic [4:0]       WB_rd,
    input  logic             WB_write_gpr,
    input  logic             WB_write_csr,
    output logic [CNT_W-1:0] inflight,
    output logic             halted,
    output logic             sb_err
);

    localparam int IDX_W = $clog2(NREG);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt [NREG];
    logic             csr_pend;

    // Bookkeeping of the slot content, kept so that a flush can undo its increments.
    logic [IDX_W-1:0] slot_rd;
    logic             slot_wgpr;
    logic             slot_wcsr;
    logic             slot_halt;

    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wb_idx;
    logic             hazard;
    logic             issue;
    logic             unwind;
    logic             retire_gpr;
    logic             err_set;
    logic             unused_addr_bits;

    assign rs1_idx = dec_rs1[IDX_W-1:0];
    assign rs2_idx = dec_rs2[IDX_W-1:0];
    assign rd_idx  = dec_rd[IDX_W-1:0];
    assign wb_idx  = WB_rd[IDX_W-1:0];
    assign unused_addr_bits = ^{dec_rs1[4:IDX_W], dec_rs2[4:IDX_W], dec_rd[4:IDX_W], WB_rd[4:IDX_W]};

    always_comb begin
        hazard = 1'b0;
        if (dec_use_rs1 && rs1_idx != '0 && cnt[rs1_idx] != '0) hazard = 1'b1;
        if (dec_use_rs2 && rs2_idx != '0 && cnt[rs2_idx] != '0) hazard = 1'b1;
        if (dec_read_csr && csr_pend)                            hazard = 1'b1;
        if (inflight == CNT_MAX)                                 hazard = 1'b1;
    end

    assign issue = IFU_valid && !hazard && !EXU_flush && (!IDU_valid || EXU_ready) &&
                   (state == ST_RUN) && !(dec_serialize && inflight != '0);
    assign IDU_ready = issue;

    // The slot was dropped before EXU took it, so its scoreboard footprint must be undone.
    assign unwind     = EXU_flush && IDU_valid && !EXU_ready;
    assign retire_gpr = WB_valid && WB_write_gpr && (wb_idx != '0);
    assign err_set    = (WB_valid && inflight == '0) || (retire_gpr && cnt[wb_idx] == '0);
    assign halted     = (state == ST_HALT);

    // Net counter update. A retire on an empty counter is ignored; sb_err reports it.
    // An unwind never drives the counter below zero, and an increment saturates.
    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                                 input logic ret,
                                                 input logic unw,
                                                 input logic inc);
        logic [CNT_W-1:0] v;
        v = c;
        if (ret && v != '0)      v = v - CNT_W'(1);
        if (unw && v != '0)      v = v - CNT_W'(1);
        if (inc && v != CNT_MAX) v = v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (issue && dec_halt)
                    state_nxt = ST_HALT;
                else if (IFU_valid && dec_serialize && inflight != '0 && !EXU_flush)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (inflight == '0)          state_nxt = ST_RUN;
            ST_HALT:  if (unwind && slot_halt)     state_nxt = ST_RUN;
            default:                               state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            inflight  <= '0;
            csr_pend  <= 1'b0;
            sb_err    <= 1'b0;
            IDU_valid <= 1'b0;
            slot_rd   <= '0;
            slot_wgpr <= 1'b0;
            slot_wcsr <= 1'b0;
            slot_halt <= 1'b0;
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= cnt_upd(inflight, WB_valid, unwind, issue);
            if (err_set) sb_err <= 1'b1;

            // A new CSR write wins over a same-cycle clear.
            if (issue && dec_write_csr)
                csr_pend <= 1'b1;
            else if ((WB_valid && WB_write_csr) || (unwind && slot_wcsr))
                csr_pend <= 1'b0;

            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_upd(cnt[i],
                                  retire_gpr && wb_idx == IDX_W'(i),
                                  unwind && slot_wgpr && slot_rd == IDX_W'(i),
                                  issue && dec_write_gpr && rd_idx != '0 && rd_idx == IDX_W'(i));
            end

            if (issue) begin
                IDU_valid <= 1'b1;
                slot_rd   <= rd_idx;
                slot_wgpr <= dec_write_gpr && (rd_idx != '0);
                slot_wcsr <= dec_write_csr;
                slot_halt <= dec_halt;
            end else if (EXU_flush || EXU_ready) begin
                IDU_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idu_issue_ctrl_ysyx23060136.sv
module tb_idu_issue_ctrl_ysyx23060136;
    localparam int MAXI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, IFU_valid, IDU_ready;
    logic [4:0] dec_rs1, dec_rs2, dec_rd, WB_rd;
    logic       dec_use_rs1, dec_use_rs2, dec_write_gpr, dec_read_csr, dec_write_csr;
    logic       dec_serialize, dec_halt, IDU_valid, EXU_ready, EXU_flush;
    logic       WB_valid, WB_write_gpr, WB_write_csr, halted, sb_err;
    logic [1:0] inflight;

    idu_issue_ctrl_ysyx23060136 dut (
        .clk(clk), .rst(rst), .IFU_valid(IFU_valid), .IDU_ready(IDU_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_write_gpr(dec_write_gpr),
        .dec_read_csr(dec_read_csr), .dec_write_csr(dec_write_csr),
        .dec_serialize(dec_serialize), .dec_halt(dec_halt), .IDU_valid(IDU_valid),
        .EXU_ready(EXU_ready), .EXU_flush(EXU_flush), .WB_valid(WB_valid), .WB_rd(WB_rd),
        .WB_write_gpr(WB_write_gpr), .WB_write_csr(WB_write_csr),
        .inflight(inflight), .halted(halted), .sb_err(sb_err)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int rd; bit wg; bit wc; } ent_t;
    ent_t exq[$];               // instructions accepted by EXU, awaiting retire
    int   m_cnt [16];
    int   m_infl;
    bit   m_csr, m_err, m_known;
    int   m_st;                 // 0 run, 1 drain, 2 halt
    bit   s_v, s_wg, s_wc, s_h;
    int   s_rd;

    bit m_haz, m_rdy, m_unw;
    int old_infl, old_st, w, r1, r2, rdm;

    initial m_known = 1'b0;

    always @(negedge clk) begin
        r1  = int'(dec_rs1[3:0]);
        r2  = int'(dec_rs2[3:0]);
        rdm = int'(dec_rd[3:0]);
        m_haz = (dec_use_rs1 && r1 != 0 && m_cnt[r1] > 0) ||
                (dec_use_rs2 && r2 != 0 && m_cnt[r2] > 0) ||
                (dec_read_csr && m_csr) || (m_infl == MAXI);
        m_rdy = IFU_valid && !m_haz && !EXU_flush && (!s_v || EXU_ready) &&
                m_st == 0 && !(dec_serialize && m_infl != 0);
        if (m_known) begin
            chk("IDU_ready", IDU_ready, m_rdy);
            chk("IDU_valid", IDU_valid, s_v);
            chk("inflight",  inflight,  m_infl);
            chk("halted",    halted,    m_st == 2);
            chk("sb_err",    sb_err,    m_err);
        end
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_infl = 0; m_csr = 0; m_err = 0; m_st = 0; s_v = 0;
            s_wg = 0; s_wc = 0; s_h = 0; s_rd = 0;
            exq.delete();
            m_known = 1'b1;
        end else begin
            old_infl = m_infl;
            old_st   = m_st;
            m_unw    = EXU_flush && s_v && !EXU_ready;
            if (s_v && EXU_ready) exq.push_back('{s_rd, s_wg, s_wc});
            // retire
            if (WB_valid) begin
                if (m_infl == 0) m_err = 1; else m_infl--;
                w = int'(WB_rd[3:0]);
                if (WB_write_gpr && w != 0) begin
                    if (m_cnt[w] == 0) m_err = 1; else m_cnt[w]--;
                end
                if (WB_write_csr) m_csr = 0;
            end
            // flush of an unaccepted slot
            if (m_unw) begin
                if (m_infl > 0) m_infl--;
                if (s_wg && s_rd != 0 && m_cnt[s_rd] > 0) m_cnt[s_rd]--;
                if (s_wc) m_csr = 0;
            end
            // issue
            if (m_rdy) begin
                if (m_infl < MAXI) m_infl++;
                if (dec_write_gpr && rdm != 0 && m_cnt[rdm] < MAXI) m_cnt[rdm]++;
                if (dec_write_csr) m_csr = 1;
            end
            // control state
            if (old_st == 0) begin
                if (m_rdy && dec_halt) m_st = 2;
                else if (IFU_valid && dec_serialize && old_infl != 0 && !EXU_flush) m_st = 1;
            end else if (old_st == 1) begin
                if (old_infl == 0) m_st = 0;
            end else if (m_unw && s_h) begin
                m_st = 0;
            end
            // slot
            if (m_rdy) begin
                s_v = 1; s_rd = rdm; s_wg = dec_write_gpr; s_wc = dec_write_csr; s_h = dec_halt;
            end else if (s_v && (EXU_flush || EXU_ready)) begin
                s_v = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        rst = 0; IFU_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_write_gpr = 0; dec_read_csr = 0;
        dec_write_csr = 0; dec_serialize = 0; dec_halt = 0; EXU_ready = 1;
        EXU_flush = 0; WB_valid = 0; WB_rd = 0; WB_write_gpr = 0; WB_write_csr = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1; clr();
    endtask

    task automatic ins(input int rd, input int rs1, input bit u1, input bit wg, input bit rc,
                       input bit wc, input bit ser, input bit hlt);
        IFU_valid = 1; dec_rd = 5'(rd); dec_rs1 = 5'(rs1); dec_use_rs1 = u1;
        dec_write_gpr = wg; dec_read_csr = rc; dec_write_csr = wc;
        dec_serialize = ser; dec_halt = hlt;
    endtask

    task automatic wb(input int rd, input bit wg, input bit wc);
        WB_valid = 1; WB_rd = 5'(rd); WB_write_gpr = wg; WB_write_csr = wc;
    endtask

    ent_t e;

    initial begin
        clr();
        rst = 1;
        @(posedge clk); #1; rst = 1;
        nxt();
        nxt(); #1;
        chk("rst_valid", IDU_valid, 0); chk("rst_inflight", inflight, 0);
        chk("rst_halted", halted, 0);   chk("rst_sberr", sb_err, 0);

        // back-to-back independent issue, then a 4th waits for a retire
        for (int k = 1; k <= 3; k++) begin
            nxt(); ins(k, 0, 0, 1, 0, 0, 0, 0); #1; chk("b2b_ready", IDU_ready, 1);
        end
        nxt(); ins(4, 0, 0, 1, 0, 0, 0, 0); wb(1, 1, 0); #1;
        chk("full_inflight", inflight, 3); chk("full_stall", IDU_ready, 0);
        nxt(); ins(4, 0, 0, 1, 0, 0, 0, 0); #1; chk("after_retire_issue", IDU_ready, 1);
        nxt(); wb(2, 1, 0);
        nxt(); wb(3, 1, 0);
        nxt(); wb(4, 1, 0);
        nxt(); #1; chk("b2b_drained", inflight, 0);

        // load-use hazard
        nxt(); ins(5, 0, 0, 1, 0, 0, 0, 0);
        nxt(); ins(6, 5, 1, 1, 0, 0, 0, 0); #1; chk("raw_stall", IDU_ready, 0);
        nxt(); ins(6, 5, 1, 1, 0, 0, 0, 0); wb(5, 1, 0); #1; chk("raw_no_bypass", IDU_ready, 0);
        nxt(); ins(6, 5, 1, 1, 0, 0, 0, 0); #1; chk("raw_release", IDU_ready, 1);
        nxt(); ins(0, 0, 0, 1, 0, 0, 0, 0); #1; chk("x0_write_issue", IDU_ready, 1);
        nxt(); ins(8, 0, 1, 0, 0, 0, 0, 0); #1; chk("x0_read_nostall", IDU_ready, 1);
        nxt(); wb(6, 1, 0);
        nxt(); wb(0, 1, 0);
        nxt(); wb(8, 0, 0);
        nxt(); #1; chk("raw_drained", inflight, 0);

        // same-cycle issue and retire of one register, then underflow
        nxt(); ins(7, 0, 0, 1, 0, 0, 0, 0);
        nxt(); ins(7, 0, 0, 1, 0, 0, 0, 0); wb(7, 1, 0);
        nxt(); ins(0, 7, 1, 0, 0, 0, 0, 0); #1;
        chk("net_inflight", inflight, 1); chk("net_cnt_stall", IDU_ready, 0);
        nxt(); ins(0, 7, 1, 0, 0, 0, 0, 0); wb(7, 1, 0); #1; chk("net_cnt_stall2", IDU_ready, 0);
        nxt(); ins(0, 7, 1, 0, 0, 0, 0, 0); #1; chk("net_cnt_release", IDU_ready, 1);
        nxt(); wb(0, 0, 0);
        nxt(); #1; chk("pre_underflow_err", sb_err, 0); wb(0, 0, 0);
        nxt(); #1; chk("underflow_err", sb_err, 1);
        nxt(); nxt(); #1; chk("underflow_sticky", sb_err, 1);

        // serialise: ecall waits for an empty pipe
        nxt(); ins(10, 0, 0, 1, 0, 0, 0, 0);
        nxt(); ins(11, 0, 0, 1, 0, 0, 0, 0);
        nxt(); ins(0, 0, 0, 0, 1, 0, 1, 0); #1; chk("ecall_stall", IDU_ready, 0);
        nxt(); ins(0, 0, 0, 0, 1, 0, 1, 0); wb(10, 1, 0);
        nxt(); ins(0, 0, 0, 0, 1, 0, 1, 0); wb(11, 1, 0);
        nxt(); ins(0, 0, 0, 0, 1, 0, 1, 0); #1; chk("drain_exit_cycle", IDU_ready, 0);
        nxt(); ins(0, 0, 0, 0, 1, 0, 1, 0); #1; chk("ecall_issue", IDU_ready, 1);
        nxt(); wb(0, 0, 0);
        // CSR read after pending CSR write
        nxt(); ins(12, 0, 0, 1, 1, 1, 0, 0);
        nxt(); ins(13, 0, 0, 1, 1, 0, 0, 0); #1; chk("csr_stall", IDU_ready, 0);
        nxt(); ins(13, 0, 0, 1, 1, 0, 0, 0); wb(12, 1, 1); #1; chk("csr_stall2", IDU_ready, 0);
        nxt(); ins(13, 0, 0, 1, 1, 0, 0, 0); #1; chk("csr_release", IDU_ready, 1);
        nxt(); wb(13, 1, 0);
        nxt(); #1; chk("csr_drained", inflight, 0);

        // flush of a held slot
        nxt(); EXU_ready = 0; ins(9, 0, 0, 1, 0, 0, 0, 0);
        nxt(); EXU_ready = 0; #1; chk("held_valid", IDU_valid, 1); chk("held_inflight", inflight, 1);
        nxt(); EXU_ready = 0; EXU_flush = 1; ins(3, 0, 0, 1, 0, 0, 0, 0); #1;
        chk("flush_no_issue", IDU_ready, 0);
        nxt(); ins(14, 9, 1, 0, 0, 0, 0, 0); #1;
        chk("flush_valid", IDU_valid, 0); chk("flush_inflight", inflight, 0);
        chk("flush_cnt_undone", IDU_ready, 1);
        nxt(); wb(14, 0, 0);
        nxt(); EXU_ready = 0; ins(0, 0, 0, 0, 0, 0, 0, 1);
        nxt(); EXU_ready = 0; #1; chk("ebreak_halted", halted, 1); EXU_flush = 1;
        nxt(); #1; chk("flushed_ebreak_run", halted, 0); chk("flushed_ebreak_valid", IDU_valid, 0);

        // halt, then reset mid-operation
        nxt(); ins(0, 0, 0, 0, 0, 0, 0, 1);
        nxt(); ins(1, 0, 0, 1, 0, 0, 0, 0); #1;
        chk("halt_state", halted, 1); chk("halt_blocks", IDU_ready, 0);
        nxt(); ins(1, 0, 0, 1, 0, 0, 0, 0); rst = 1; #1; chk("pre_rst_err", sb_err, 1);
        nxt(); #1;
        chk("rst2_valid", IDU_valid, 0); chk("rst2_inflight", inflight, 0);
        chk("rst2_halted", halted, 0);   chk("rst2_sberr", sb_err, 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst           = ($urandom % 300 == 0) || (m_st == 2 && $urandom % 15 == 0);
            EXU_ready     = ($urandom % 10) < 7;
            EXU_flush     = ($urandom % 25) == 0;
            IFU_valid     = ($urandom % 10) < 8;
            dec_rd        = 5'($urandom % 16);
            dec_rs1       = 5'($urandom % 16);
            dec_rs2       = 5'($urandom % 16);
            dec_use_rs1   = $urandom % 2;
            dec_use_rs2   = $urandom % 2;
            dec_write_gpr = ($urandom % 4) != 0;
            dec_read_csr  = ($urandom % 7) == 0;
            dec_write_csr = ($urandom % 9) == 0;
            dec_serialize = ($urandom % 20) == 0;
            dec_halt      = ($urandom % 60) == 0;
            if (exq.size() > 0 && ($urandom % 2) == 0) begin
                e = exq.pop_front();
                wb(e.rd, e.wg, e.wc);
            end
        end
        nxt(); nxt();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/idu_issue_ctrl_ysyx23060136.md
# idu_issue_ctrl_ysyx23060136

Issue controller between IFU and EXU on the NPC core. It accepts one decoded instruction per cycle from the decode stage and holds it in a registered valid/ready output slot. A per-GPR pending-write scoreboard and a CSR-pending flag stall RAW hazards. The block also serialises ecall/mret, halts on ebreak, and unwinds its own bookkeeping on EXU flush.

## Interface
- `MAX_INFLIGHT`, default 3: max issued-but-not-retired instructions; also the saturation value of each scoreboard counter.
- `NREG`, default 16: GPR count (RV32E); register index = low `$clog2(NREG)` bits of each 5-bit address.
- `CNT_W`, derived as `$clog2(MAX_INFLIGHT+1)`: counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high, single clock domain.
- `IFU_valid` in 1: decoded instruction present.
- `IDU_ready` out 1: instruction accepted this cycle (issue).
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: register addresses.
- `dec_use_rs1`, `dec_use_rs2` in 1 each: operand actually read.
- `dec_write_gpr` in 1: writes rd.
- `dec_read_csr` in 1: reads a CSR (csrrw/csrrs/ecall/mret).
- `dec_write_csr` in 1: writes a CSR.
- `dec_serialize` in 1: ecall/mret; must issue with an empty pipe.
- `dec_halt` in 1: ebreak.
- `IDU_valid` out 1: output slot valid to EXU.
- `EXU_ready` in 1: EXU accepts the slot.
- `EXU_flush` in 1: redirect; drop the slot.
- `WB_valid` in 1: an instruction retires.
- `WB_rd` in 5: its rd.
- `WB_write_gpr` in 1: it wrote a GPR.
- `WB_write_csr` in 1: it wrote a CSR.
- `inflight` out `CNT_W`: issued-not-retired count.
- `halted` out 1: in HALT state.
- `sb_err` out 1: sticky; set on retire underflow.

## Operation
- **FSM states:** RUN, DRAIN, HALT.
- **Hazard** (combinational from inputs and registered state), true when any of:
  - `dec_use_rs1` & rs1≠0 & cnt[rs1]≠0
  - the same condition for rs2
  - `dec_read_csr` & `csr_pend`
  - `inflight==MAX_INFLIGHT`
- **Issue:** `IDU_ready = IFU_valid & ~hazard & ~EXU_flush & (~IDU_valid | EXU_ready) & state==RUN & ~(dec_serialize & inflight≠0)`.
  - If `dec_serialize` is set and `inflight≠0`, the FSM moves RUN→DRAIN. It returns to RUN when `inflight==0`. No issue occurs in DRAIN.
- **On issue:**
  - The slot loads and `IDU_valid` is set to 1.
  - `inflight` increments.
  - If `dec_write_gpr` & rd≠0, cnt[rd] increments.
  - If `dec_write_csr`, `csr_pend` is set.
  - The slot stores rd, the write flags and the halt flag for flush unwind.
- **Retire (`WB_valid`):**
  - `inflight` decrements.
  - If `WB_write_gpr` & rd≠0, cnt[WB_rd] decrements.
  - If `WB_write_csr`, `csr_pend` clears.
  - If the counter is already 0: no change, `sb_err` is set.
- **Simultaneous issue and retire:** applied as net arithmetic. The same register gives an unchanged count; `inflight` is unchanged.
  - Retire and a new CSR write in the same cycle leave `csr_pend` set.
- **Flush (`EXU_flush`):**
  - `IDU_valid` clears.
  - If the slot was valid and not accepted this cycle, its scoreboard increments are reversed: cnt[rd]−1, `inflight`−1, `csr_pend` cleared if the slot set it.
  - A halt in the dropped slot returns the FSM from HALT to RUN.
  - No issue occurs in the flush cycle.
- **Handshake:**
  - Slot clears when `EXU_ready & IDU_valid` and no new issue occurs.
  - Slot contents are stable while `IDU_valid & ~EXU_ready`.
- **Halt:** issuing with `dec_halt` moves the FSM to HALT.
  - `halted` is set to 1 and no further issue occurs.
  - Only `rst` or a flush of that slot leaves HALT.
- **Reset values:** `IDU_valid`=0, `inflight`=0, all cnt=0, `csr_pend`=0, `halted`=0, `sb_err`=0, state=RUN.

## Timing
- **Issue latency:** issue in cycle t sets `IDU_valid`=1 in cycle t+1.
- **Back-to-back issue:** full throughput, 1 instruction/cycle, when `EXU_ready` is held at 1 and there is no hazard.
- **No bypass:** a retire in cycle t clears the hazard in cycle t+1. The earliest dependent issue is therefore t+1.
- `IDU_ready` is combinational, so upstream must not make `IFU_valid` depend on `IDU_ready`.
- **Reset mid-operation:** all state clears at the next edge, and the in-flight contents of the slot are discarded.

## Test plan
- **Back-to-back issue:** three independent addi (rd=1,2,3) with `EXU_ready`=1 → issued on consecutive cycles, then `inflight`=3.
  - A 4th instruction stalls until the first `WB_valid`, then issues one cycle later.
- **Load-use RAW:** lw rd=5, then add rs1=5 → `IDU_ready`=0.
  - Retire rd=5 at cycle t → add issues at t+1, with cnt[5] ending at 0.
  - rs1=x0 with a pending x0 write never stalls.
- **Same-cycle issue/retire:** issue rd=7 while WB retires rd=7 with cnt[7]=1 → cnt[7] stays 1 and `inflight` is unchanged.
  - Retire with cnt=0 → `sb_err`=1 and is sticky until reset.
- **Serialise:** ecall with `inflight`=2 → DRAIN; two retires → RUN; ecall issues in the next cycle.
  - csrrs issued after a pending csrrw stalls until `WB_write_csr`.
- **Flush:** slot holds rd=9 with `EXU_ready`=0; assert `EXU_flush` → `IDU_valid`=0, cnt[9]=0, `inflight`−1, no issue that cycle.
  - A flushed ebreak slot clears `halted`.
- **Halt and reset:** issue ebreak → `halted`=1 and `IFU_valid` is ignored.
  - Assert `rst` for 1 cycle → every output is at its reset value on the next cycle.
